// File: rtl/wide_add_seq.sv
// rtl/wide_add_seq.sv - sequential W-bit add/subtract using one shared 16-bit adder slice

module add_slice16 (
    input  logic [15:0] x_i,
    input  logic [15:0] y_i,
    input  logic        carry_i,
    output logic [15:0] sum_o,
    output logic        carry_o
);
    // 16-bit add with carry in and carry out
    assign {carry_o, sum_o} = {1'b0, x_i} + {1'b0, y_i} + {16'd0, carry_i};
endmodule

module wide_add_seq #(
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [16*WORDS-1:0]  a,
    input  logic [16*WORDS-1:0]  b,
    input  logic                 op,
    input  logic                 cin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [16*WORDS-1:0]  sum,
    output logic                 cout,
    output logic                 ovf,
    output logic                 busy
);
    localparam int W  = 16 * WORDS;
    localparam int IW = $clog2(WORDS);
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;       // already inverted for subtract
    logic [W-1:0]    sum_q;
    logic            carry_q;
    logic [IW-1:0]   idx_q;
    logic [IW-1:0]   idx_d;
    logic            cout_q;
    logic            ovf_q;

    logic [15:0]     slice_x;
    logic [15:0]     slice_y;
    logic [15:0]     slice_sum;
    logic            slice_co;

    // operands for the slice currently being evaluated
    assign slice_x = a_q[{idx_q, 4'b0000} +: 16];
    assign slice_y = b_q[{idx_q, 4'b0000} +: 16];
    assign idx_d   = idx_q + 1'b1;

    add_slice16 u_slice (
        .x_i     (slice_x),
        .y_i     (slice_y),
        .carry_i (carry_q),
        .sum_o   (slice_sum),
        .carry_o (slice_co)
    );

    // accept, one slice per RUN cycle, hold result in DONE until handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= op ? ~b : b;
                        carry_q <= op ? 1'b1 : cin;
                        idx_q   <= '0;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    sum_q[{idx_q, 4'b0000} +: 16] <= slice_sum;
                    carry_q <= slice_co;
                    if (idx_q == LAST_IDX) begin
                        cout_q  <= slice_co;
                        ovf_q   <= (a_q[W-1] == b_q[W-1]) & (slice_sum[15] != a_q[W-1]);
                        state_q <= S_DONE;
                    end else begin
                        idx_q <= idx_d;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE) & ~rst;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_wide_add_seq.sv
// tb/tb_wide_add_seq.sv - scoreboard bench for wide_add_seq
module tb_wide_add_seq;
    localparam int WORDS = 4;
    localparam int W     = 16 * WORDS;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         op = 1'b0;
    logic         cin = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready;
    logic         out_valid;
    logic         cout;
    logic         ovf;
    logic         busy;
    logic [W-1:0] sum;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         v;
        int           acc;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   ready_mode = 1;
    bit   seen_rise = 1'b0;
    bit   hs_pend = 1'b0;

    wide_add_seq #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk64(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // independent reference: unsigned carry/borrow and exact signed result range
    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic mop, input logic mcin);
        exp_t         r;
        logic [W:0]   u;
        logic [W+1:0] ex;
        if (mop) begin
            u   = {1'b0, ma} - {1'b0, mb};
            r.c = (ma >= mb);
            ex  = {{2{ma[W-1]}}, ma} - {{2{mb[W-1]}}, mb};
        end else begin
            u   = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mcin};
            r.c = u[W];
            ex  = {{2{ma[W-1]}}, ma} + {{2{mb[W-1]}}, mb} + {{(W+1){1'b0}}, mcin};
        end
        r.s   = u[W-1:0];
        r.v   = !((ex[W+1:W-1] == 3'b000) || (ex[W+1:W-1] == 3'b111));
        r.acc = 0;
        return r;
    endfunction

    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb2, input logic top,
                         input logic tcin, input logic [W-1:0] es, input logic ec,
                         input logic ev, input bit push);
        int   n = 0;
        exp_t e;
        while (in_ready !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        chk1("accept_wait", in_ready, 1'b1);
        a        = ta;
        b        = tb2;
        op       = top;
        cin      = tcin;
        in_valid = 1'b1;
        if (push) begin
            e.s   = es;
            e.c   = ec;
            e.v   = ev;
            e.acc = cyc + 1;
            sb.push_back(e);
        end
        step();
        in_valid = 1'b0;
        a        = {$urandom, $urandom};
        b        = {$urandom, $urandom};
        op       = 1'($urandom);
        cin      = 1'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            step();
            n++;
        end
        chk64("drain_empty", W'(sb.size()), '0);
        step();
        step();
    endtask

    // monitor: drives out_ready, checks handshake rules and pops results
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            case (ready_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
            if (rst) begin
                chk1("rst_in_ready", in_ready, 1'b0);
                seen_rise = 1'b0;
                hs_pend   = 1'b0;
            end else begin
                chk1("in_ready_rule", in_ready, !busy);
                chk1("valid_implies_busy", out_valid && !busy, 1'b0);
                if (hs_pend) begin
                    chk1("post_hs_valid", out_valid, 1'b0);
                    chk1("post_hs_ready", in_ready, 1'b1);
                    hs_pend = 1'b0;
                end
                if (out_valid) begin
                    if (sb.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_result: got sum %h with no pending operation", sum);
                    end else begin
                        e = sb[0];
                        if (!seen_rise) begin
                            chk64("latency", W'(cyc - e.acc), W'(WORDS));
                            seen_rise = 1'b1;
                        end
                        chk64("sum", sum, e.s);
                        chk1("cout", cout, e.c);
                        chk1("ovf", ovf, e.v);
                        if (out_ready) begin
                            void'(sb.pop_front());
                            seen_rise = 1'b0;
                            hs_pend   = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // stimulus
    initial begin
        exp_t e;
        logic [W-1:0] ra, rb;
        logic         rop, rcin;

        rst = 1'b1;
        repeat (3) step();
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_cout", cout, 1'b0);
        chk1("rst_ovf", ovf, 1'b0);
        chk64("rst_sum", sum, '0);
        chk1("rst_in_ready_low", in_ready, 1'b0);
        rst = 1'b0;
        #1;
        chk1("ready_after_rst", in_ready, 1'b1);

        ready_mode = 1;
        issue(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b1);
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1);
        issue(64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1);
        issue(64'h5, 64'h7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b1);
        issue(64'h7, 64'h5, 1'b1, 1'b0, 64'h2, 1'b1, 1'b0, 1'b1);
        issue(64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b1);
        issue(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 1'b1);
        drain();

        // backpressure in DONE with competing requests
        ready_mode = 0;
        issue(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, 1'b0,
              64'h1234_5678_9ABC_DF00, 1'b0, 1'b0, 1'b1);
        begin
            int n = 0;
            while (out_valid !== 1'b1 && n < 50) begin
                step();
                n++;
            end
        end
        chk1("bp_valid", out_valid, 1'b1);
        for (int i = 0; i < 10; i++) begin
            in_valid = ~in_valid;
            a        = {$urandom, $urandom};
            b        = {$urandom, $urandom};
            step();
            chk1("bp_in_ready", in_ready, 1'b0);
            chk1("bp_hold_valid", out_valid, 1'b1);
        end
        in_valid   = 1'b0;
        ready_mode = 1;
        begin
            int n = 0;
            while (out_valid !== 1'b0 && n < 50) begin
                step();
                n++;
            end
        end
        chk1("bp_ready_after", in_ready, 1'b1);
        issue(64'h3, 64'h4, 1'b0, 1'b1, 64'h8, 1'b0, 1'b0, 1'b1);
        drain();

        // reset in RUN at slice 1; the aborted operation must never report
        issue(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        step();
        chk1("abort_busy", busy, 1'b1);
        rst = 1'b1;
        step();
        chk1("abort_out_valid", out_valid, 1'b0);
        chk1("abort_busy_low", busy, 1'b0);
        chk64("abort_sum", sum, '0);
        chk1("abort_in_ready_low", in_ready, 1'b0);
        rst = 1'b0;
        #1;
        chk1("abort_in_ready", in_ready, 1'b1);
        issue(64'h1, 64'h2, 1'b0, 1'b0, 64'h3, 1'b0, 1'b0, 1'b1);
        drain();

        // random operations with random consumer stalls
        ready_mode = 2;
        for (int i = 0; i < 1000; i++) begin
            ra   = {$urandom, $urandom};
            rb   = {$urandom, $urandom};
            rop  = 1'($urandom);
            rcin = 1'($urandom);
            e    = model(ra, rb, rop, rcin);
            issue(ra, rb, rop, rcin, e.s, e.c, e.v, 1'b1);
        end
        drain();
        ready_mode = 1;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
